// File: rtl/ledr_pkg.sv
// Shared types and helpers for the LEDR write arbiter: FSM state encoding,
// the PIO data register address, and the circular round-robin search.
package ledr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } state_t;

    localparam logic [1:0] LEDR_ADDR_DATA = 2'd0;

    // Widest requester set supported by rr_next.
    localparam int unsigned MAX_REQ = 8;

    // First set bit of req searching circularly from last+1 (mod nreq).
    // Returns last unchanged when no bit in the active range is set.
    function automatic logic [2:0] rr_next(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last,
        input int unsigned        nreq
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= nreq) begin
                idx = (32'(last) + k) % nreq;
                if (!found && req[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ledr_write_arbiter_pick.sv
// Combinational circular priority encoder: winner is the first requester
// after the last granted index, wrapping at NREQ.
module rr_priority_pick
    import ledr_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2:0] pick;

    always_comb begin
        pick  = rr_next(8'(req), 3'(last), 32'(NREQ));
        valid = |req;
        idx   = IDX_W'(pick);
    end

endmodule

// File: rtl/ledr_write_arbiter.sv
// Round-robin arbiter driving single-cycle writes into the LEDR PIO, with a
// hold-off period after each write so every value stays visible.
module ledr_write_arbiter
    import ledr_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DATA_W      = 4,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           ack,
    output logic [1:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [31:0]               avm_writedata,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_idx
);

    localparam int IDX_W         = $clog2(NREQ);
    localparam int CNT_W         = (HOLD_CYCLES > 0) ? (($clog2(HOLD_CYCLES + 1) > 0) ? $clog2(HOLD_CYCLES + 1) : 1) : 1;
    localparam int HOLD_LOAD_INT = (HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_LOAD_INT);

    logic [DATA_W-1:0] slice [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [NREQ-1:0]   ack_reg;
    logic [1:0]        address_reg;
    logic              chipselect_reg;
    logic              write_n_reg;
    logic [31:0]       writedata_reg;
    logic              busy_reg;
    logic [IDX_W-1:0]  grant_idx_reg;

    rr_priority_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .last  (grant_idx_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Strobes and ack are registered on the grant edge so they appear
    // during the WRITE cycle itself; writedata doubles as the data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            ack_reg        <= '0;
            address_reg    <= LEDR_ADDR_DATA;
            chipselect_reg <= 1'b0;
            write_n_reg    <= 1'b1;
            writedata_reg  <= '0;
            busy_reg       <= 1'b0;
            grant_idx_reg  <= IDX_W'(NREQ - 1);
        end else begin
            ack_reg        <= '0;
            chipselect_reg <= 1'b0;
            write_n_reg    <= 1'b1;
            address_reg    <= LEDR_ADDR_DATA;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        state_reg         <= WRITE;
                        grant_idx_reg     <= pick_idx;
                        writedata_reg     <= 32'(slice[pick_idx]);
                        ack_reg[pick_idx] <= 1'b1;
                        chipselect_reg    <= 1'b1;
                        write_n_reg       <= 1'b0;
                        busy_reg          <= 1'b1;
                    end
                end
                WRITE: begin
                    if (HOLD_CYCLES == 0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= HOLD;
                        cnt_reg   <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ack            = ack_reg;
    assign avm_address    = address_reg;
    assign avm_chipselect = chipselect_reg;
    assign avm_write_n    = write_n_reg;
    assign avm_writedata  = writedata_reg;
    assign busy           = busy_reg;
    assign grant_idx      = grant_idx_reg;

endmodule

// File: tb/tb_ledr_write_arbiter.sv
// Randomised and directed stimulus against a cycle-level reference model of
// the arbiter; expected writes go through a scoreboard queue to a monitor.
module tb_ledr_write_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 4;
    localparam int HOLD   = 3;

    logic                    clk;
    logic                    reset;
    logic [NREQ-1:0]         req;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic [NREQ-1:0]         ack;
    logic [1:0]              avm_address;
    logic                    avm_chipselect;
    logic                    avm_write_n;
    logic [31:0]             avm_writedata;
    logic                    busy;
    logic [1:0]              grant_idx;

    ledr_write_arbiter #(
        .NREQ        (NREQ),
        .DATA_W      (DATA_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_data       (req_data),
        .ack            (ack),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .busy           (busy),
        .grant_idx      (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;

    // Reference model state, advanced once per rising edge.
    bit          m_valid = 0;
    int          edge_n = 0;
    int          free_edge = 0;
    int          grant_edge = -1000;
    int          m_last = NREQ - 1;
    logic [31:0] m_wdata = '0;
    bit          m_busy = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int rr_ref(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int  w;
        wr_t e;
        edge_n++;
        if (reset) begin
            m_valid    = 1;
            m_last     = NREQ - 1;
            free_edge  = edge_n + 1;
            grant_edge = -1000;
            m_wdata    = '0;
        end else if (m_valid && edge_n >= free_edge && req != '0) begin
            w          = rr_ref(req, m_last);
            e.idx      = w;
            e.data     = 32'(req_data[w*DATA_W +: DATA_W]);
            sb_q.push_back(e);
            m_last     = w;
            m_wdata    = e.data;
            grant_edge = edge_n;
            free_edge  = edge_n + HOLD + 2;
        end
        m_busy = m_valid && !reset && edge_n >= grant_edge && edge_n <= grant_edge + HOLD;
    end

    always @(negedge clk) begin
        wr_t             e;
        logic [NREQ-1:0] exp_ack;
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("grant_idx", 32'(grant_idx), 32'(m_last));
            chk("writedata", avm_writedata, m_wdata);
            chk("address", 32'(avm_address), 32'd0);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                exp_ack = '0;
                exp_ack[e.idx] = 1'b1;
                writes_seen++;
                $display("write #%0d: req=%0d data=%h ack=%b cs=%b wn=%b", writes_seen, e.idx, e.data, ack, avm_chipselect, avm_write_n);
                chk("write_strobe", {30'd0, avm_chipselect, avm_write_n}, 32'b10);
                chk("write_ack", 32'(ack), 32'(exp_ack));
                chk("write_data", avm_writedata, e.data);
            end else begin
                chk("idle_strobe", {30'd0, avm_chipselect, avm_write_n}, 32'b01);
                chk("idle_ack", 32'(ack), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [3:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        tick(2);
        reset = 1'b0;

        // Single request: write of 0xA, then hold-off.
        req = 4'b0001;
        set_data(0, 4'hA);
        tick(1);
        req = '0;
        tick(8);

        // All requesters asserted: rotation with per-slice data.
        req_data = 16'h4321;
        req = 4'b1111;
        tick(5 * (HOLD + 2) + 1);
        req = '0;
        tick(8);

        // Wrap-around: last grant 1, then 0 and 1 both request -> 0 wins.
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(8);
        req_data = 16'h8765;
        req = 4'b0011;
        tick(1);
        req = '0;
        tick(8);

        // Data changed right after the grant does not affect the write.
        set_data(2, 4'h5);
        req = 4'b0100;
        tick(1);
        set_data(2, 4'hC);
        req = '0;
        tick(10);

        // Pulse only during HOLD is lost.
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(2);
        req = 4'b1000;
        tick(1);
        req = '0;
        tick(10);

        // Reset mid-HOLD, pending requests restart with requester 0.
        req = 4'b1111;
        tick(5 * (HOLD + 2) + 2);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3 * (HOLD + 2));
        req = '0;
        tick(8);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            reset    = ($urandom_range(0, 99) == 0);
            req      = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 15));
            req_data = 16'($urandom);
            tick(1);
        end
        reset = 1'b0;
        req   = '0;
        tick(HOLD + 4);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("writes_nonzero", 32'(writes_seen > 20), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
